// File: rtl/sat_add_signed.sv
// Registered two's-complement saturating adder with positive/negative clamp flags.
// Optional saturation event counter compiled in with `define SAT_ADD_SAT_COUNT_EN.
module sat_add_signed #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a_in,
    input  logic signed [WIDTH-1:0] b_in,
    output logic signed [WIDTH-1:0] sum_out,
    output logic                    out_valid,
    output logic                    sat_pos,
    output logic                    sat_neg
`ifdef SAT_ADD_SAT_COUNT_EN
    ,
    output logic [CNT_W-1:0]        sat_count,
    input  logic                    sat_count_clr
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_param_chk
        $error("sat_add_signed: illegal WIDTH or CNT_W");
    end

    logic [WIDTH:0]   raw;
    logic             pos_ovf;
    logic             neg_ovf;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             pos_d, pos_q;
    logic             neg_d, neg_q;
    logic             vld_q;

    // The extra sign bit makes the top two bits disagree exactly when the sum overflows.
    assign raw     = {a_in[WIDTH-1], a_in} + {b_in[WIDTH-1], b_in};
    assign pos_ovf = ~raw[WIDTH] &  raw[WIDTH-1];
    assign neg_ovf =  raw[WIDTH] & ~raw[WIDTH-1];

    always_comb begin
        sum_d = sum_q;
        pos_d = pos_q;
        neg_d = neg_q;
        if (in_valid) begin
            pos_d = pos_ovf;
            neg_d = neg_ovf;
            if (pos_ovf)      sum_d = MAX_VAL;
            else if (neg_ovf) sum_d = MIN_VAL;
            else              sum_d = raw[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            pos_q <= 1'b0;
            neg_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            pos_q <= pos_d;
            neg_q <= neg_d;
            vld_q <= in_valid;
        end
    end

    assign sum_out   = sum_q;
    assign out_valid = vld_q;
    assign sat_pos   = pos_q;
    assign sat_neg   = neg_q;

`ifdef SAT_ADD_SAT_COUNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (sat_count_clr)
            cnt_d = '0;
        else if (in_valid && (pos_ovf || neg_ovf) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_sat_add_signed.sv
// Scoreboard bench for sat_add_signed: driver pushes clamped reference results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_sat_add_signed;

    localparam int W    = 8;
    localparam int SMAX = 127;
    localparam int SMIN = -128;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] a_in = '0;
    logic signed [W-1:0] b_in = '0;
    logic signed [W-1:0] sum_out;
    logic                out_valid, sat_pos, sat_neg;
`ifdef SAT_ADD_SAT_COUNT_EN
    logic [15:0]         sat_count;
    logic                sat_count_clr = 1'b0;
    logic signed [W-1:0] sum2;
    logic                vld2, pos2, neg2;
    logic [1:0]          cnt2;
`endif

    sat_add_signed #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .sum_out(sum_out), .out_valid(out_valid), .sat_pos(sat_pos), .sat_neg(sat_neg)
`ifdef SAT_ADD_SAT_COUNT_EN
        , .sat_count(sat_count), .sat_count_clr(sat_count_clr)
`endif
    );

`ifdef SAT_ADD_SAT_COUNT_EN
    sat_add_signed #(.WIDTH(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .sum_out(sum2), .out_valid(vld2), .sat_pos(pos2), .sat_neg(neg2),
        .sat_count(cnt2), .sat_count_clr(sat_count_clr)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        bit pos;
        bit neg;
        int c16;
        int c2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_c16    = 0;
    int   m_c2     = 0;
    int   last_sum = 0;
    bit   last_pos = 0;
    bit   last_neg = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int a, input int b, input bit v, input bit clr);
        exp_t e;
        int   s;
        @(negedge clk);
        a_in     = W'(a);
        b_in     = W'(b);
        in_valid = v;
        s = int'(W'(a) >>> 0);
        s = int'($signed(W'(a))) + int'($signed(W'(b)));
        e.pos = (s > SMAX);
        e.neg = (s < SMIN);
        e.sum = e.pos ? SMAX : (e.neg ? SMIN : s);
`ifdef SAT_ADD_SAT_COUNT_EN
        sat_count_clr = clr;
        if (clr) begin
            m_c16 = 0;
            m_c2  = 0;
        end else if (v && (e.pos || e.neg)) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c2 < 3)      m_c2++;
        end
`endif
        e.c16 = m_c16;
        e.c2  = m_c2;
        if (v) q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sum"},   int'(sum_out), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_pos"},   int'(sat_pos), 0);
        chk({tag, "_neg"},   int'(sat_neg), 0);
`ifdef SAT_ADD_SAT_COUNT_EN
        chk({tag, "_count"}, int'(sat_count), 0);
`endif
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SAT_ADD_SAT_COUNT_EN
        sat_count_clr = 1'b0;
`endif
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        q.delete();
        last_sum = 0; last_pos = 0; last_neg = 0;
        m_c16 = 0; m_c2 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", int'(sum_out), e.sum);
                    chk("sat_pos", int'(sat_pos), int'(e.pos));
                    chk("sat_neg", int'(sat_neg), int'(e.neg));
`ifdef SAT_ADD_SAT_COUNT_EN
                    chk("sat_count", int'(sat_count), e.c16);
                    chk("sat_count_w2", int'(cnt2), e.c2);
                    chk("sum_w2inst", int'(sum2), e.sum);
`endif
                    last_sum = e.sum;
                    last_pos = e.pos;
                    last_neg = e.neg;
                end
            end else begin
                chk("hold_sum", int'(sum_out), last_sum);
                chk("hold_pos", int'(sat_pos), int'(last_pos));
                chk("hold_neg", int'(sat_neg), int'(last_neg));
            end
        end
    end

    initial begin
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(100, -10, 1, 0);
        drive(100, 100, 1, 0);
        drive(127, 1, 1, 0);
        drive(-100, -100, 1, 0);
        drive(-128, -128, 1, 0);
        drive(-128, 127, 1, 0);
        drive(127, 0, 1, 0);
        drive(127, 127, 1, 0);
        drive(-128, -1, 1, 0);
        drive(0, 0, 0, 0);
        drive(5, 5, 0, 0);

`ifdef SAT_ADD_SAT_COUNT_EN
        drive(0, 0, 0, 1);
        drive(100, 100, 1, 0);
        drive(1, 2, 1, 0);
        drive(-100, -100, 1, 0);
        drive(-5, 3, 1, 0);
        drive(127, 1, 1, 0);
        drive(100, 100, 1, 1);
        drive(100, 100, 1, 0);
        drive(-100, -100, 1, 0);
        drive(127, 127, 1, 0);
        drive(-128, -128, 1, 0);
        drive(90, 90, 1, 0);
        drive(0, 0, 0, 0);
`endif

        for (int i = 0; i < 100; i++)
            drive(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1, 0);

        mid_reset();
        drive(-7, 20, 1, 0);

        for (int i = 0; i < 60; i++)
            drive(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  ($urandom_range(3) != 0), ($urandom_range(9) == 0));

        mid_reset();
        drive(60, 70, 1, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_add_signed.md
Name: sat_add_signed

Overview:
- Registered two's-complement saturating adder.
- Adds two signed WIDTH-bit operands and clamps the result to the representable signed range instead of wrapping.
- Reports positive or negative saturation per result.
- Used in the PID datapath wherever integrator or error terms are summed, so an overflow can never flip the sign.

Parameters:
- WIDTH, 8, operand and result width in bits (signed two's complement); legal range 2..32.
- CNT_W, 16, width of the saturation event counter (only used when the optional feature is compiled in).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on a_in/b_in are valid this cycle.
- a_in  input  WIDTH  signed operand A.
- b_in  input  WIDTH  signed operand B.
- sum_out  output  WIDTH  signed saturated sum (registered).
- out_valid  output  1  sum_out/flags updated by a valid input on the previous cycle.
- sat_pos  output  1  last result clamped to +max.
- sat_neg  output  1  last result clamped to -min.
- sat_count  output  CNT_W  saturation event count (optional feature only).
- sat_count_clr  input  1  synchronous clear of sat_count (optional feature only).

Behaviour:
- Reset (async assert, sync release): sum_out=0, out_valid=0, sat_pos=0, sat_neg=0, sat_count=0.
- Raw sum is computed at WIDTH+1 bits with both operands sign-extended; no wrap is permitted.
- MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1).
- raw > MAX: result = MAX, sat_pos=1.
- raw < MIN: result = MIN, sat_neg=1.
- Otherwise: result = raw[WIDTH-1:0], both flags 0.
- Detection is equivalent to: operand signs equal AND result sign differs. sat_pos and sat_neg are never both 1.
- Latency is 1 cycle. When in_valid=1 at a rising edge, sum_out, sat_pos and sat_neg load the result and out_valid=1 on the next cycle.
- When in_valid=0: out_valid goes 0; sum_out and the flags hold their previous values.
- There is no backpressure; a new operand pair is accepted every cycle (throughput 1/cycle).
- Boundary cases:
  - MAX+0 = MAX, with no flag.
  - MIN+MAX = -1.
  - MIN+MIN = MIN, sat_neg=1.
  - MAX+MAX = MAX, sat_pos=1.
  - MAX+1 = MAX, sat_pos=1.
  - MIN+(-1) = MIN, sat_neg=1.
- Reset asserted mid-stream clears all outputs immediately, without waiting for a clock edge. The first valid input after release produces a result one cycle later.
- sum_out is declared signed. Downstream consumers treat it as signed.

Optional Feature:
- Macro: SAT_ADD_SAT_COUNT_EN.
- Defined:
  - The sat_count and sat_count_clr ports exist.
  - sat_count increments by 1 on each accepted input (in_valid=1) whose result saturates in either direction.
  - The counter itself saturates at 2^CNT_W-1 and never wraps.
  - sat_count_clr=1 sets it to 0 on the next edge; clear has priority over a same-cycle increment.
  - Reset sets it to 0.
- Not defined: the sat_count and sat_count_clr ports are absent, and no counter logic is generated.

Test Plan:
- Nominal: a=100, b=-10, in_valid=1 -> next cycle sum_out=90, out_valid=1, sat_pos=0, sat_neg=0.
- Positive clamp: a=100, b=100 -> sum_out=127, sat_pos=1. Then a=127, b=1 -> sum_out=127, sat_pos=1.
- Negative clamp: a=-100, b=-100 -> sum_out=-128, sat_neg=1. Then a=-128, b=-128 -> sum_out=-128, sat_neg=1. Then a=-128, b=127 -> sum_out=-1, no flag.
- Random: 100 random signed 8-bit pairs at 1/cycle -> each sum_out equals a scoreboard clamp(a+b,-128,127), delayed one cycle, with consistent flags.
- Reset/valid: assert rst mid-stream -> outputs 0 without a clock edge. Hold in_valid=0 -> sum_out holds and out_valid=0.
- Optional (SAT_ADD_SAT_COUNT_EN): 3 saturating and 2 non-saturating inputs -> sat_count=3. Pulse sat_count_clr together with a saturating input -> sat_count=0. With CNT_W=2, 5 saturations -> sat_count=3.
